spi_frame_receiver: RTL and testbench
=====================================

// Module: spi_frame_receiver
// PURPOSE
//   SPI front end between package pins (ui_in[0..2]) and the register file that drives pwm_peripheral.
//   Synchronises SCLK/COPI/nCS into clk, deserialises 16-bit mode-0 frames MSB-first, and validates them.
//   Emits each accepted write as a one-cycle {addr,data} strobe; malformed frames are dropped and flagged.
// PARAMETERS
//   SYNC_STAGES  2      flops per input synchroniser (>=2)
//   FRAME_BITS   16     bits per frame: [15]=R/W (1=write), [14:8]=addr, [7:0]=data
//   ADDR_W       7      address width
//   DATA_W       8      data width
//   MAX_ADDR     7'h04  highest legal register address
// PORTS
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   sclk_i     in   1       SPI clock, async to clk (mode 0)
//   copi_i     in   1       SPI data in, async
//   ncs_i      in   1       SPI chip select, active low, async
//   wr_valid   out  1       one-cycle pulse: accepted write frame
//   wr_addr    out  ADDR_W  address of last accepted write; held until next accept
//   wr_data    out  DATA_W  data of last accepted write; held until next accept
//   frame_err  out  1       one-cycle pulse: frame dropped (bad length or address)
//   busy       out  1       high while a frame is in progress (synchronised nCS low)
// BEHAVIOUR
//   Reset: clk and rst_n as stated above; all outputs 0, shift reg 0, bit count 0, FSM IDLE, sync flops 1 for nCS, 0 otherwise.
//   Sync: each input through SYNC_STAGES flops plus one history flop; edges = sync_out vs history.
//   FSM IDLE: wait for nCS fall -> SHIFT (clear bit_cnt, clear ovf).
//   FSM SHIFT: on SCLK rise, shift {sr[14:0], copi_sync}; bit_cnt++ saturating at FRAME_BITS;
//     an SCLK rise with bit_cnt==FRAME_BITS sets ovf. nCS rise -> COMMIT.
//   FSM COMMIT (one cycle): evaluate and return to IDLE:
//     bit_cnt!=16 or ovf                 -> frame_err=1, no write
//     R/W=0 (read)                       -> silently ignored (write-only block), no err
//     addr>MAX_ADDR                      -> frame_err=1, no write
//     otherwise                          -> wr_valid=1, wr_addr/wr_data updated same edge
//   Latency (SYNC_STAGES=2): clk edge k first samples ncs_i high -> wr_valid/frame_err high for cycle after edge k+3.
//   SCLK falls ignored; SCLK/COPI ignored while nCS synchronised high.
//   Same-cycle SCLK rise and nCS rise: nCS wins, that SCLK edge is not shifted.
//   nCS fall while in COMMIT: COMMIT completes, then FSM enters SHIFT next cycle (fall edge not lost:
//     IDLE also enters SHIFT if ncs_sync is low). Min nCS-high time for back-to-back frames: 4 clk.
//   Reset mid-frame: partial frame discarded, no wr_valid/frame_err; next full frame decoded normally.
//   SCLK must be <= clk/4 for correct capture; faster is unsupported (no detection).
// STRUCTURE
//   Package spi_frame_pkg: FRAME_BITS, ADDR_W, DATA_W, MAX_ADDR, state enum {IDLE, SHIFT, COMMIT},
//     field slice constants (RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8).
//   Sub-module sync_edge_detect (param SYNC_STAGES, RESET_VAL): outputs level, rise, fall; instantiated 3x.
//   Top: FSM, 16-bit shift reg, 5-bit bit counter with ovf flag, output registers.
// TESTING
//   Write 16'h80A5 (addr 0, data A5), SCLK=clk/8 -> one wr_valid, wr_addr=0, wr_data=A5, frame_err=0.
//   Write 16'h8533 (addr 5 > MAX_ADDR) -> frame_err pulse, no wr_valid, wr_addr/wr_data unchanged.
//   15-bit then 17-bit frames -> frame_err pulse each, no wr_valid; read 16'h0412 -> neither pulse.
//   Back-to-back writes 16'h8280, 16'h84FF with 4-clk nCS gap -> two wr_valid, values 02/80 then 04/FF.
//   rst_n low after 8 bits of a frame, release, send 16'h8111 -> only one wr_valid, addr 1, data 11.
//   Latency check: ncs_i rise aligned to clk edge -> wr_valid exactly 3 edges later; busy tracks nCS.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared constants, field positions and FSM state type for the SPI frame receiver.
package spi_frame_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 5;

  localparam logic [ADDR_W-1:0] MAX_ADDR = 7'h04;

  localparam int unsigned RW_BIT   = 15;
  localparam int unsigned ADDR_MSB = 14;
  localparam int unsigned ADDR_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one async input, plus a history flop for edge detection.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 write-only frame receiver: synchronises pins, deserialises 16-bit frames,
// validates length/address and emits one-cycle write or error strobes.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_i,
  input  logic              copi_i,
  input  logic              ncs_i,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic ncs_lvl,  ncs_rise,  ncs_fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk_i),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi_i),
    .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs_i),
    .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  // Mode 0 samples on SCLK rise only; COPI edges are irrelevant.
  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

  state_e state_q, state_d;

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // IDLE checks the level, not just the fall, so a fall during COMMIT is not lost.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ncs_fall || !ncs_lvl) state_d = SHIFT;
      SHIFT:   if (ncs_rise)             state_d = COMMIT;
      COMMIT:                            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    ovf_d       = ovf_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (ncs_fall || !ncs_lvl) begin
          bit_cnt_d = '0;
          ovf_d     = 1'b0;
        end
      end
      SHIFT: begin
        // nCS rise takes priority over a coincident SCLK rise.
        if (!ncs_rise && sclk_rise) begin
          sr_d = {sr_q[FRAME_BITS-2:0], copi_lvl};
          if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
            ovf_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        if (bit_cnt_q != CNT_W'(FRAME_BITS) || ovf_q) begin
          frame_err_d = 1'b1;
        end else if (!sr_q[RW_BIT]) begin
          frame_err_d = 1'b0;
        end else if (sr_q[ADDR_MSB:ADDR_LSB] > MAX_ADDR) begin
          frame_err_d = 1'b1;
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = sr_q[ADDR_MSB:ADDR_LSB];
          wr_data_d  = sr_q[DATA_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      ovf_q       <= ovf_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign frame_err = frame_err_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = ~ncs_lvl;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench: SPI frames at clk/8, transaction-level outcome model, per-cycle compare.
module tb_spi_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk_i = 1'b0;
  logic       copi_i = 1'b0;
  logic       ncs_i = 1'b1;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  spi_frame_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         rst_rel = 1000000;
  int         tests = 0;
  int         fails = 0;
  int         nval = 0;
  int         nerr = 0;
  bit         ncs_seen [int];
  logic [1:0] exp_pulse [int];
  logic [6:0] exp_a [int];
  logic [7:0] exp_d [int];
  logic [6:0] m_addr = '0;
  logic [7:0] m_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Outcome of a whole frame as {write, error}.
  function automatic logic [1:0] predict(input logic [16:0] v, input int n);
    if (n != 16) return 2'b01;
    if (v[15] == 1'b0) return 2'b00;
    if (int'(v[14:8]) > 4) return 2'b01;
    return 2'b10;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    ncs_seen[cyc] = ncs_i;
  end

  initial forever begin
    logic [1:0] p;
    @(negedge clk);
    #1;
    p = exp_pulse.exists(cyc) ? exp_pulse[cyc] : 2'b00;
    if (!rst_n) begin
      m_addr = '0;
      m_data = '0;
      p = 2'b00;
    end else if (p[1]) begin
      m_addr = exp_a[cyc];
      m_data = exp_d[cyc];
    end
    chk("wr_valid", {31'd0, wr_valid}, {31'd0, p[1]});
    chk("frame_err", {31'd0, frame_err}, {31'd0, p[0]});
    chk("wr_addr", {25'd0, wr_addr}, {25'd0, m_addr});
    chk("wr_data", {24'd0, wr_data}, {24'd0, m_data});
    if (!rst_n)
      chk("busy_rst", {31'd0, busy}, 32'd0);
    else if (cyc >= rst_rel + 3)
      chk("busy", {31'd0, busy}, {31'd0, ~ncs_seen[cyc-1]});
    if (wr_valid) nval++;
    if (frame_err) nerr++;
  end

  task automatic send_bits(input logic [16:0] v, input int n);
    ncs_i  = 1'b0;
    sclk_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      copi_i = v[i];
      repeat (4) @(negedge clk);
      sclk_i = 1'b1;
      repeat (4) @(negedge clk);
      sclk_i = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [16:0] v, input int n, input int gap);
    int c;
    logic [1:0] p;
    send_bits(v, n);
    repeat (4) @(negedge clk);
    ncs_i = 1'b1;
    c = cyc;
    p = predict(v, n);
    if (p != 2'b00) begin
      exp_pulse[c+4] = p;
      exp_a[c+4]     = v[14:8];
      exp_d[c+4]     = v[7:0];
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ncs_i  = 1'b1;
    sclk_i = 1'b0;
    copi_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    rst_rel = cyc;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [16:0] v;
    int          n;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    rst_rel = cyc;
    repeat (6) @(negedge clk);
    chk("reset_addr", {25'd0, wr_addr}, 32'd0);
    chk("reset_data", {24'd0, wr_data}, 32'd0);

    send_frame(17'h080A5, 16, 8);
    chk("w80A5_addr", {25'd0, wr_addr}, 32'h00);
    chk("w80A5_data", {24'd0, wr_data}, 32'hA5);
    chk("w80A5_nval", nval, 1);
    chk("w80A5_nerr", nerr, 0);

    send_frame(17'h08533, 16, 8);
    chk("badaddr_nerr", nerr, 1);
    chk("badaddr_nval", nval, 1);
    chk("badaddr_data", {24'd0, wr_data}, 32'hA5);

    send_frame(17'h00A5A, 15, 8);
    send_frame(17'h1A5A5, 17, 8);
    send_frame(17'h00412, 16, 8);
    chk("len_nerr", nerr, 3);
    chk("len_nval", nval, 1);

    send_frame(17'h08280, 16, 4);
    send_frame(17'h084FF, 16, 8);
    chk("b2b_nval", nval, 3);
    chk("b2b_addr", {25'd0, wr_addr}, 32'h04);
    chk("b2b_data", {24'd0, wr_data}, 32'hFF);

    send_bits(17'h08777, 8);
    do_reset();
    chk("rstmid_addr", {25'd0, wr_addr}, 32'h00);
    send_frame(17'h08111, 16, 8);
    chk("rstmid_nval", nval, 4);
    chk("rstmid_nerr", nerr, 3);
    chk("rstmid_addr2", {25'd0, wr_addr}, 32'h01);
    chk("rstmid_data2", {24'd0, wr_data}, 32'h11);

    for (int k = 0; k < 30; k++) begin
      v = 17'($urandom);
      v[14:8] = 7'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) n = ($urandom_range(0, 1) == 1) ? 15 : 17;
      else n = 16;
      send_frame(v, n, int'($urandom_range(4, 10)));
    end
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
